// File: rtl/board_checker.sv
// board_checker: scans an N x N board through a one-cycle-latency read port and
// reports how many cells share the colour of cell (0,0).
// Ports: CLOCK / RESET_N  clock and asynchronous active-low reset
//        SIZE             board dimension N, latched at the start edge
//        CHECK_REQ        rising edge (seen in IDLE) starts a scan
//        ABORT            cancels a scan in progress
//        RD_EN/RD_ROW/RD_COL  read request and cell address
//        RD_DATA          cell colour, valid the cycle after RD_EN
//        BUSY / DONE      scan in progress / one-cycle result pulse
//        WIN / MATCH_COUNT / ANCHOR_COLOR  results of the last completed scan
module board_checker #(
    parameter int MAX_SIZE = 26
) (
    input  logic       CLOCK,
    input  logic       RESET_N,
    input  logic [4:0] SIZE,
    input  logic       CHECK_REQ,
    input  logic       ABORT,
    output logic       RD_EN,
    output logic [4:0] RD_ROW,
    output logic [4:0] RD_COL,
    input  logic [2:0] RD_DATA,
    output logic       BUSY,
    output logic       DONE,
    output logic       WIN,
    output logic [9:0] MATCH_COUNT,
    output logic [2:0] ANCHOR_COLOR
);
    typedef enum logic [2:0] {IDLE, ANCHOR, SCAN, DRAIN, REPORT} state_t;

    state_t     r_state, w_next;
    logic       r_prev, r_cap, r_cmp;
    logic [4:0] r_n, r_row, r_col;
    logic [2:0] r_anchor;
    logic [9:0] r_cnt;
    logic       w_start, w_size_ok, w_col_end, w_last, w_hit;
    logic [9:0] w_total, w_final;

    always_comb begin
        w_start   = r_state == IDLE && CHECK_REQ && !r_prev && !ABORT;
        w_size_ok = SIZE >= 5'd2 && {27'd0, SIZE} <= MAX_SIZE;
        w_col_end = r_col == r_n - 5'd1;
        w_last    = w_col_end && r_row == r_n - 5'd1;
        // r_cmp marks cycles whose RD_DATA answers a SCAN read, so (0,0) is
        // compared once against the separately captured anchor
        w_hit     = r_cmp && RD_DATA == r_anchor;
        w_final   = r_cnt + {9'd0, w_hit};
        w_total   = {5'd0, r_n} * {5'd0, r_n};
        w_next    = r_state;
        case (r_state)
            IDLE:    if (w_start) w_next = w_size_ok ? ANCHOR : REPORT;
            ANCHOR:  w_next = SCAN;
            SCAN:    if (w_last) w_next = DRAIN;
            DRAIN:   w_next = REPORT;
            default: w_next = IDLE;
        endcase
        if (ABORT && r_state != IDLE) w_next = IDLE;
        RD_EN  = r_state == ANCHOR || r_state == SCAN;
        RD_ROW = r_state == SCAN ? r_row : 5'd0;
        RD_COL = r_state == SCAN ? r_col : 5'd0;
        BUSY   = r_state == ANCHOR || r_state == SCAN || r_state == DRAIN;
        DONE   = r_state == REPORT;
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state      <= IDLE;
            r_prev       <= 1'b0;
            r_cap        <= 1'b0;
            r_cmp        <= 1'b0;
            r_n          <= '0;
            r_row        <= '0;
            r_col        <= '0;
            r_anchor     <= '0;
            r_cnt        <= '0;
            WIN          <= 1'b0;
            MATCH_COUNT  <= '0;
            ANCHOR_COLOR <= '0;
        end else begin
            r_state <= w_next;
            r_prev  <= CHECK_REQ;
            r_cap   <= r_state == ANCHOR;
            r_cmp   <= r_state == SCAN;
            if (w_start) r_n <= SIZE;
            if (r_cap) r_anchor <= RD_DATA;
            if (r_state == ANCHOR) begin
                r_cnt <= '0;
                r_row <= '0;
                r_col <= '0;
            end else begin
                if (w_hit) r_cnt <= r_cnt + 10'd1;
                if (r_state == SCAN) begin
                    r_col <= w_col_end ? 5'd0 : r_col + 5'd1;
                    if (w_col_end) r_row <= r_row + 5'd1;
                end
            end
            // REPORT is entered either from DRAIN (real result) or straight
            // from IDLE on an illegal size (cleared result)
            if (w_next == REPORT) begin
                MATCH_COUNT  <= r_state == DRAIN ? w_final : 10'd0;
                WIN          <= r_state == DRAIN && w_final == w_total;
                ANCHOR_COLOR <= r_state == DRAIN ? r_anchor : 3'd0;
            end
        end
    end
endmodule

// File: tb/tb_board_checker.sv
// tb_board_checker: randomized and directed checks of board_checker against a cycle-count model.
module tb_board_checker;
    logic       CLOCK = 1'b0, RESET_N = 1'b0, CHECK_REQ = 1'b0, ABORT = 1'b0;
    logic [4:0] SIZE = '0;
    logic [2:0] RD_DATA = '0;
    logic       RD_EN, BUSY, DONE, WIN;
    logic [4:0] RD_ROW, RD_COL;
    logic [9:0] MATCH_COUNT;
    logic [2:0] ANCHOR_COLOR;
    logic [2:0] board [0:31][0:31];
    logic       exp_win = 1'b0;
    logic [9:0] exp_mc = '0;
    logic [2:0] exp_anc = '0;
    int         errors = 0, checks = 0;

    board_checker dut (
        .CLOCK(CLOCK), .RESET_N(RESET_N), .SIZE(SIZE), .CHECK_REQ(CHECK_REQ), .ABORT(ABORT),
        .RD_EN(RD_EN), .RD_ROW(RD_ROW), .RD_COL(RD_COL), .RD_DATA(RD_DATA),
        .BUSY(BUSY), .DONE(DONE), .WIN(WIN), .MATCH_COUNT(MATCH_COUNT), .ANCHOR_COLOR(ANCHOR_COLOR)
    );

    always #5 CLOCK = ~CLOCK;

    always @(posedge CLOCK) RD_DATA <= RD_EN ? board[RD_ROW][RD_COL] : 3'($urandom);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge CLOCK);
        #1;
    endtask

    task automatic fill(input bit rnd, input logic [2:0] colour);
        for (int r = 0; r < 32; r++)
            for (int c = 0; c < 32; c++)
                board[r][c] = (rnd && $urandom_range(0, 3) == 0) ? 3'($urandom) : colour;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rd_en"}, RD_EN, 0);
        chk({tag, "_rd_row"}, RD_ROW, 0);
        chk({tag, "_rd_col"}, RD_COL, 0);
        chk({tag, "_busy"}, BUSY, 0);
        chk({tag, "_done"}, DONE, 0);
        chk({tag, "_win"}, WIN, 0);
        chk({tag, "_mc"}, MATCH_COUNT, 0);
        chk({tag, "_anchor"}, ANCHOR_COLOR, 0);
    endtask

    // mode: 0 plain, 1 CHECK_REQ held high, 2 ABORT at t0+10, 3 reset at t0+5,
    //       4 start edge supplied by reset release with CHECK_REQ already high
    task automatic scan(input int n, input int mode);
        int nn, last, cnt, idx, d;
        bit ok, gone, e_rd, e_busy, e_done;
        logic [4:0] e_row, e_col;
        ok = n >= 2 && n <= 26;
        nn = n * n;
        d = n > 0 ? n : 1;
        last = ok ? nn + 3 : 1;
        cnt = 0;
        for (int r = 0; r < n; r++)
            for (int c = 0; c < n; c++)
                if (board[r][c] == board[0][0]) cnt++;
        step();
        SIZE = 5'(n);
        CHECK_REQ = 1'b1;
        ABORT = 1'b0;
        if (mode == 4) RESET_N = 1'b1;
        for (int k = 1; k <= last + 3; k++) begin
            step();
            if (mode == 3 && k == 5) begin
                RESET_N = 1'b0;
                #1;
                chk_all_zero("mid_reset");
                exp_win = 1'b0;
                exp_mc = '0;
                exp_anc = '0;
                CHECK_REQ = 1'b0;
                step();
                RESET_N = 1'b1;
                for (int j = 0; j < 4; j++) begin
                    step();
                    chk("post_reset_done", DONE, 0);
                    chk("post_reset_busy", BUSY, 0);
                end
                return;
            end
            gone = mode == 2 && k > 10;
            idx = k - 2;
            e_rd = ok && !gone && k <= nn + 1;
            e_row = (e_rd && k > 1) ? 5'(idx / d) : 5'd0;
            e_col = (e_rd && k > 1) ? 5'(idx % d) : 5'd0;
            e_busy = ok && !gone && k <= nn + 2;
            e_done = !gone && k == last;
            if (e_done) begin
                exp_mc = ok ? 10'(cnt) : 10'd0;
                exp_win = ok && cnt == nn;
                exp_anc = ok ? board[0][0] : 3'd0;
            end
            chk("rd_en", RD_EN, e_rd);
            chk("rd_row", RD_ROW, e_row);
            chk("rd_col", RD_COL, e_col);
            chk("busy", BUSY, e_busy);
            chk("done", DONE, e_done);
            chk("win", WIN, exp_win);
            chk("match_count", MATCH_COUNT, exp_mc);
            chk("anchor_color", ANCHOR_COLOR, exp_anc);
            SIZE = 5'($urandom);
            CHECK_REQ = mode == 1 ? 1'b1 : (k < (mode == 2 ? 11 : last)) ? 1'($urandom) : 1'b0;
            ABORT = mode == 2 && k == 10;
        end
        CHECK_REQ = 1'b0;
        ABORT = 1'b0;
    endtask

    initial begin
        repeat (2) step();
        chk_all_zero("reset");
        fill(0, 3'd3);
        scan(2, 4);
        fill(0, 3'd4);
        board[5][5] = 3'd1;
        scan(6, 0);
        fill(1, 3'($urandom));
        scan(6, 2);
        step();
        SIZE = 5'd4;
        CHECK_REQ = 1'b1;
        ABORT = 1'b1;
        step();
        chk("abort_start_busy", BUSY, 0);
        chk("abort_start_rd_en", RD_EN, 0);
        ABORT = 1'b0;
        step();
        chk("held_req_busy", BUSY, 0);
        CHECK_REQ = 1'b0;
        fill(0, 3'd0);
        scan(26, 1);
        scan(1, 0);
        scan(0, 0);
        scan(31, 0);
        fill(1, 3'($urandom));
        scan(5, 3);
        for (int i = 0; i < 10; i++) begin
            fill(1, 3'($urandom));
            scan(int'($urandom_range(2, 12)), 0);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
